// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one synchronous FIFO write port between
// NUM_REQ producers. An owner is picked in IDLE, then holds the port for up to
// MAX_BURST words before ownership rotates. There is one bubble cycle between
// bursts. Writes are throttled with full/almostfull so the FIFO never overflows.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req, req_data    per-requester word-valid (level) and packed data words
//   gnt              one-hot take strobe (combinational); the word is taken this cycle
//   owner, owner_vld current burst owner and its valid flag
//   fifo_data_in     registered FIFO write data
//   fifo_wr_en       registered FIFO write enable
//   fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow   FIFO status inputs
//   wr_count         count of accepted writes (wraps)
//   ovf_err, clr_err sticky overflow flag and its clear input
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          owner_vld,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [15:0]                   wr_count,
  output logic                          ovf_err,
  input  logic                          clr_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic                 owner_vld_q;
  logic [BC_W-1:0]      burst_cnt_q;
  logic                 fifo_wr_en_q;
  logic [FIFO_WIDTH-1:0] fifo_data_q;
  logic [15:0]          wr_count_q;
  logic [15:0]          wr_count_d;
  logic                 ovf_err_q;
  logic                 ovf_err_d;

  logic                 can_write_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic                 take_s;
  logic [IDX_W-1:0]     sel_s;
  logic [IDX_W-1:0]     next_ptr_s;
  logic                 last_word_s;

  // At most one write is in flight: with almostfull set, a write already
  // issued may consume the last slot, so no new word is taken.
  assign can_write_s = !fifo_full && !(fifo_almostfull && fifo_wr_en_q);

  // Take strobe for the owner only while in a burst and the FIFO can accept.
  always_comb begin
    gnt_s = '0;
    if ((state_q == ST_BURST) && req[owner_q] && can_write_s) begin
      gnt_s[owner_q] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign take_s      = |gnt_s;
  assign last_word_s = (burst_cnt_q == BC_W'(MAX_BURST - 1));
  assign next_ptr_s  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Circular scan from rr_ptr; descending loop so the smallest offset wins.
  always_comb begin
    int cand;
    sel_s = rr_ptr_q;
    cand  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (req[IDX_W'(cand)]) begin
        sel_s = IDX_W'(cand);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Burst ownership FSM; every exit to IDLE advances rr_ptr past the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            owner_q     <= sel_s;
            owner_vld_q <= 1'b1;
            burst_cnt_q <= '0;
            state_q     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!req[owner_q] || (can_write_s && last_word_s)) begin
            state_q     <= ST_IDLE;
            owner_vld_q <= 1'b0;
            rr_ptr_q    <= next_ptr_s;
            burst_cnt_q <= '0;
          end else if (can_write_s) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          owner_vld_q <= 1'b0;
          burst_cnt_q <= '0;
        end
      endcase
    end
  end

  // Registered FIFO write port; data holds its last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      fifo_wr_en_q <= take_s;
      if (take_s) begin
        fifo_data_q <= req_data[owner_q*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Next values for the write counter and sticky overflow flag (set wins).
  always_comb begin
    wr_count_d = wr_count_q;
    ovf_err_d  = ovf_err_q;
    if (fifo_wr_ack) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    if (fifo_overflow) begin
      ovf_err_d = 1'b1;
    end else if (clr_err) begin
      ovf_err_d = 1'b0;
    end else begin
      ovf_err_d = ovf_err_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= 16'd0;
      ovf_err_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign gnt          = gnt_s;
  assign owner        = owner_q;
  assign owner_vld    = owner_vld_q;
  assign fifo_data_in = fifo_data_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign wr_count     = wr_count_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           owner_vld;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic           fifo_almostfull;
  logic           fifo_wr_ack;
  logic           fifo_overflow;
  logic [15:0]    wr_count;
  logic           ovf_err;
  logic           clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  // producer model
  int          rem [N];
  logic [15:0] seq [N];

  // depth-8 FIFO model
  logic force_full, ovf_pulse, drain, fifo_clr;
  int   fcnt;

  // captured outputs for the current cycle
  logic [N-1:0] g_s;
  logic         we_s, vld_s, af_s, ovi_s;
  logic [W-1:0] d_s;
  logic [1:0]   own_s;

  always #5 clk = ~clk;

  assign fifo_full       = force_full || (fcnt >= 8);
  assign fifo_almostfull = (fcnt >= 7);
  assign fifo_wr_ack     = fifo_wr_en && (fcnt < 8);
  assign fifo_overflow   = ovf_pulse || (fifo_wr_en && (fcnt >= 8));

  always @(posedge clk) begin
    if (fifo_clr) fcnt <= 0;
    else fcnt <= fcnt + ((fifo_wr_en && fcnt < 8) ? 1 : 0) - ((drain && fcnt > 0) ? 1 : 0);
  end

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .owner(owner), .owner_vld(owner_vld), .fifo_data_in(fifo_data_in),
    .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow), .wr_count(wr_count),
    .ovf_err(ovf_err), .clr_err(clr_err)
  );

  function automatic logic [15:0] data_of(input int k, input int n);
    return 16'(k * 4096 + n);
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k] = (rem[k] > 0);
      req_data[k*W +: W] = data_of(k, int'(seq[k]));
    end
  endtask

  // one cycle: drive at negedge, sample, retire granted words, next negedge
  task automatic tick();
    drive();
    #1;
    g_s = gnt; we_s = fifo_wr_en; d_s = fifo_data_in; own_s = owner;
    vld_s = owner_vld; af_s = fifo_almostfull; ovi_s = fifo_overflow;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        rem[k] = rem[k] - 1;
        seq[k] = seq[k] + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fifo_clr = 1'b1;
    force_full = 1'b0; ovf_pulse = 1'b0; clr_err = 1'b0; drain = 1'b1;
    for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 16'd0; end
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (owner_vld !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_data_in !== 16'd0 ||
        wr_count !== 16'd0 || ovf_err !== 1'b0 || gnt !== 4'b0000 || owner !== 2'd0) begin
      $display("FAIL reset_state: vld=%b wr_en=%b data=%h cnt=%0d ovf=%b gnt=%b owner=%0d, want all 0",
               owner_vld, fifo_wr_en, fifo_data_in, wr_count, ovf_err, gnt, owner);
      n_fail++;
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [N-1:0] exp_g;
    logic         exp_we;
    int           nw;
    do_reset();
    rem[2] = 6;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_g  = (c inside {1, 2, 3, 4, 6, 7}) ? 4'b0100 : 4'b0000;
      exp_we = (c inside {2, 3, 4, 5, 7, 8});
      n_checks++;
      if (g_s !== exp_g) begin
        $display("FAIL single_gnt c=%0d: got %b want %b", c, g_s, exp_g); n_fail++;
      end
      n_checks++;
      if (we_s !== exp_we) begin
        $display("FAIL single_wr_en c=%0d: got %b want %b", c, we_s, exp_we); n_fail++;
      end
      if (exp_we) begin
        n_checks++;
        if (d_s !== data_of(2, nw)) begin
          $display("FAIL single_data c=%0d: got %h want %h", c, d_s, data_of(2, nw)); n_fail++;
        end
        nw++;
      end
    end
    n_checks++;
    if (wr_count !== 16'd6) begin
      $display("FAIL single_wr_count: got %0d want 6", wr_count); n_fail++;
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g;
    int p;
    do_reset();
    for (int k = 0; k < N; k++) rem[k] = 1000;
    for (int c = 0; c < 26; c++) begin
      tick();
      p = (c - 1) % 5;
      if (c == 0 || p == 4) exp_g = 4'b0000;
      else exp_g = 4'(1 << (((c - 1) / 5) % 4));
      n_checks++;
      if (g_s !== exp_g) begin
        $display("FAIL rotation_gnt c=%0d: got %b want %b", c, g_s, exp_g); n_fail++;
      end
    end
  endtask

  task automatic test_full_stall();
    logic [N-1:0] exp_g;
    do_reset();
    rem[1] = 4; rem[2] = 4;
    for (int c = 0; c < 13; c++) begin
      force_full = (c >= 2 && c <= 6);
      tick();
      if (c inside {1, 7, 8, 9}) exp_g = 4'b0010;
      else if (c inside {11, 12}) exp_g = 4'b0100;
      else exp_g = 4'b0000;
      n_checks++;
      if (g_s !== exp_g) begin
        $display("FAIL stall_gnt c=%0d: got %b want %b", c, g_s, exp_g); n_fail++;
      end
      if (c >= 3 && c <= 6) begin
        n_checks++;
        if (we_s !== 1'b0 || own_s !== 2'd1 || vld_s !== 1'b1) begin
          $display("FAIL stall_hold c=%0d: wr_en=%b owner=%0d vld=%b want 0/1/1", c, we_s, own_s, vld_s);
          n_fail++;
        end
      end
      if (c == 8) begin
        n_checks++;
        if (we_s !== 1'b1 || d_s !== data_of(1, 1)) begin
          $display("FAIL stall_resume_data: wr_en=%b data=%h want 1/%h", we_s, d_s, data_of(1, 1));
          n_fail++;
        end
      end
    end
    force_full = 1'b0;
  endtask

  task automatic test_fill();
    int pulses;
    do_reset();
    drain = 1'b0;
    for (int k = 0; k < N; k++) rem[k] = 1000;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (we_s) pulses++;
      n_checks++;
      if ((af_s && we_s && (g_s != 4'b0000)) || ovi_s) begin
        $display("FAIL fill_guard c=%0d: gnt=%b almostfull=%b wr_en=%b overflow=%b", c, g_s, af_s, we_s, ovi_s);
        n_fail++;
      end
    end
    n_checks++;
    if (pulses != 8) begin
      $display("FAIL fill_pulses: got %0d want 8", pulses); n_fail++;
    end
    n_checks++;
    if (ovf_err !== 1'b0 || wr_count !== 16'd8) begin
      $display("FAIL fill_status: ovf_err=%b wr_count=%0d want 0/8", ovf_err, wr_count); n_fail++;
    end
    drain = 1'b1;
  endtask

  task automatic test_ovf_err();
    do_reset();
    ovf_pulse = 1'b1; clr_err = 1'b1;
    @(negedge clk);
    ovf_pulse = 1'b0; clr_err = 1'b0;
    #1;
    n_checks++;
    if (ovf_err !== 1'b1) begin
      $display("FAIL ovf_set_wins: got %b want 1", ovf_err); n_fail++;
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    n_checks++;
    if (ovf_err !== 1'b0) begin
      $display("FAIL ovf_clear: got %b want 0", ovf_err); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rem[2] = 10;
    ovf_pulse = 1'b1;
    tick();
    ovf_pulse = 1'b0;
    tick();
    tick();
    // now owner=2 with two words taken
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (owner_vld !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_data_in !== 16'd0 ||
        wr_count !== 16'd0 || ovf_err !== 1'b0 || gnt !== 4'b0000 || owner !== 2'd0) begin
      $display("FAIL async_reset: vld=%b wr_en=%b data=%h cnt=%0d ovf=%b gnt=%b owner=%0d, want all 0",
               owner_vld, fifo_wr_en, fifo_data_in, wr_count, ovf_err, gnt, owner);
      n_fail++;
    end
    rem[2] = 0; rem[1] = 5; rem[3] = 5;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (g_s !== 4'b0010 || own_s !== 2'd1 || vld_s !== 1'b1) begin
      $display("FAIL post_reset_owner: gnt=%b owner=%0d vld=%b want 0010/1/1", g_s, own_s, vld_s);
      n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b0; fifo_clr = 1'b1; force_full = 1'b0; ovf_pulse = 1'b0;
    clr_err = 1'b0; drain = 1'b1; fcnt = 0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 16'd0; end
    drive();
    test_reset();
    test_single_burst();
    test_rotation();
    test_full_stall();
    test_fill();
    test_ovf_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
